// File: rtl/seg7_pkg.sv
// Shared constants and the active-low hex glyph table for the 7-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Bit order: seg[0]=a .. seg[6]=g; a 0 lights the segment.
  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = hex_pattern(nibble);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller with a tear-free one-deep write shadow.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL    = NUM_DIGITS'(AN_OFF);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  logic [CNT_W-1:0]      slot_cnt, slot_cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_W-1:0]     active, active_nxt;
  logic [DATA_W-1:0]     pending, pending_nxt;
  logic                  pend_v, pend_v_nxt;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  logic       slot_end_c, frame_end_c, wr_acc_c, commit_c, blank_c;
  logic [3:0] nibble_c;
  logic [6:0] glyph_c;

  seg7_hex_dec u_dec (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // Next-state: prescaler, digit index, shadow handshake and output decode.
  always_comb begin
    slot_cnt_nxt = slot_cnt;
    idx_nxt      = idx;
    active_nxt   = active;
    pending_nxt  = pending;
    pend_v_nxt   = pend_v;

    slot_end_c  = (slot_cnt == SLOT_LAST);
    frame_end_c = slot_end_c && (idx == IDX_LAST);
    wr_acc_c    = wr_en && wr_ready;
    commit_c    = frame_end_c && pend_v;

    if (slot_end_c) begin
      slot_cnt_nxt = '0;
      idx_nxt      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      slot_cnt_nxt = slot_cnt + CNT_W'(1);
    end

    // Commit and accept are exclusive because wr_ready tracks !pend_v.
    if (commit_c) begin
      active_nxt = pending;
      pend_v_nxt = 1'b0;
    end
    if (wr_acc_c) begin
      pending_nxt = wr_data;
      pend_v_nxt  = 1'b1;
    end

    nibble_c = active[32'(idx) * 4 +: 4];
    blank_c  = (slot_cnt < BLANK_LIM) || !digit_en[idx];
    an_nxt   = blank_c ? AN_ALL : ~(AN_ONE << idx);
    seg_nxt  = blank_c ? SEG_BLANK : glyph_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_v     <= 1'b0;
      wr_ready   <= 1'b1;
      seg        <= SEG_BLANK;
      an         <= AN_ALL;
      frame_done <= 1'b0;
    end else begin
      slot_cnt   <= slot_cnt_nxt;
      idx        <= idx_nxt;
      active     <= active_nxt;
      pending    <= pending_nxt;
      pend_v     <= pend_v_nxt;
      wr_ready   <= !pend_v_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= frame_end_c;
    end
  end

endmodule
